// File: rtl/gunshot_direction_detector.sv
// Multi-channel gunshot detector: debounced per-channel threshold trigger, windowed
// peak capture, dominant-channel direction report and post-event cooldown.
module gunshot_direction_detector #(
   parameter int  NUM_CH   = 4,
   parameter int  DATA_W   = 16,
   parameter int  HOLD     = 3,
   parameter int  WINDOW   = 16,
   parameter int  COOLDOWN = 64,
   localparam int CH_W     = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [1:0]               kernel_size,
   input  logic                     cfg_we,
   input  logic [1:0]               cfg_sel,
   input  logic [DATA_W-1:0]        cfg_thr,
   input  logic                     in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic                     detected,
   output logic                     dir_valid,
   output logic [CH_W-1:0]          dir_ch,
   output logic signed [DATA_W-1:0] dir_peak,
   output logic [NUM_CH-1:0]        hit_mask
);

   localparam int RUN_W = $clog2(HOLD + 1);
   localparam int WIN_W = $clog2(WINDOW + 1);
   localparam int CD_W  = $clog2(COOLDOWN + 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
   localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COOLDOWN - 1);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_REPORT, S_COOLDOWN} state_t;

   state_t                    state, state_nxt;
   logic signed [DATA_W-1:0]  thr      [3];
   logic signed [DATA_W-1:0]  peak     [NUM_CH];
   logic signed [DATA_W-1:0]  peak_nxt [NUM_CH];
   logic signed [DATA_W-1:0]  sample   [NUM_CH];
   logic [RUN_W-1:0]          run      [NUM_CH];
   logic [WIN_W-1:0]          win_cnt;
   logic [CD_W-1:0]           cd_cnt;
   logic [1:0]                ks_l, ks_nxt;
   logic signed [DATA_W-1:0]  thr_cur, thr_rep, best_peak;
   logic [CH_W-1:0]           best_ch;
   logic [NUM_CH-1:0]         over, hit_nxt;
   logic                      trigger, to_report;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      thr_cur = '0;
      case (kernel_size)
         2'd0:    thr_cur = thr[0];
         2'd1:    thr_cur = thr[1];
         2'd2:    thr_cur = thr[2];
         default: thr_cur = '0;
      endcase
      trigger = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         sample[i] = in_data[i*DATA_W +: DATA_W];
         over[i]   = (kernel_size != 2'd3) && (sample[i] > thr_cur);
         if (over[i] && (int'(run[i]) + 1 >= HOLD))
            trigger = 1'b1;
      end
      trigger = trigger && in_valid && enable && (state == S_IDLE);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (trigger) state_nxt = (WINDOW == 1) ? S_REPORT : S_CAPTURE;
         S_CAPTURE:  if (in_valid && win_cnt == WIN_LAST) state_nxt = S_REPORT;
         S_REPORT:   state_nxt = S_COOLDOWN;
         S_COOLDOWN: if (in_valid && cd_cnt == CD_LAST) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
      if (!enable) state_nxt = S_IDLE;
      to_report = (state_nxt == S_REPORT) && (state != S_REPORT);
   end

   // Result is computed from the peaks as they will be after this edge, so the
   // registered direction is ready in the very cycle dir_valid is high.
   always_comb begin
      ks_nxt  = trigger ? kernel_size : ks_l;
      thr_rep = '0;
      case (ks_nxt)
         2'd0:    thr_rep = thr[0];
         2'd1:    thr_rep = thr[1];
         2'd2:    thr_rep = thr[2];
         default: thr_rep = '0;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
         if (state == S_IDLE)
            peak_nxt[i] = sample[i];
         else
            peak_nxt[i] = (sample[i] > peak[i]) ? sample[i] : peak[i];
         hit_nxt[i] = (ks_nxt != 2'd3) && (peak_nxt[i] > thr_rep);
      end
      best_ch   = '0;
      best_peak = peak_nxt[0];
      for (int i = 1; i < NUM_CH; i++) begin
         if (peak_nxt[i] > best_peak) begin
            best_ch   = CH_W'(i);
            best_peak = peak_nxt[i];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         // NOTE: thresholds are a small register file that must come up with defaults, so it is reset.
         thr[0]   <= DATA_W'(200);
         thr[1]   <= DATA_W'(500);
         thr[2]   <= DATA_W'(1000);
         for (int i = 0; i < NUM_CH; i++) begin
            peak[i] <= '0;
            run[i]  <= '0;
         end
         win_cnt  <= '0;
         cd_cnt   <= '0;
         ks_l     <= '0;
         dir_ch   <= '0;
         dir_peak <= '0;
         hit_mask <= '0;
      end else begin
         state <= state_nxt;
         if (cfg_we && cfg_sel != 2'd3)
            thr[cfg_sel] <= cfg_thr;

         if (!enable) begin
            for (int i = 0; i < NUM_CH; i++) run[i] <= '0;
            win_cnt <= '0;
            cd_cnt  <= '0;
         end else begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (state != S_IDLE || trigger)
                  run[i] <= '0;
               else if (in_valid && !over[i])
                  run[i] <= '0;
               else if (in_valid && run[i] != RUN_W'(HOLD))
                  run[i] <= run[i] + 1'b1;
            end

            if (trigger)
               win_cnt <= WIN_W'(1);
            else if (state == S_CAPTURE && in_valid)
               win_cnt <= win_cnt + 1'b1;
            else if (state == S_REPORT)
               win_cnt <= '0;

            if (state == S_REPORT)
               cd_cnt <= '0;
            else if (state == S_COOLDOWN && in_valid)
               cd_cnt <= cd_cnt + 1'b1;

            if (trigger || (state == S_CAPTURE && in_valid))
               for (int i = 0; i < NUM_CH; i++) peak[i] <= peak_nxt[i];
            if (trigger)
               ks_l <= kernel_size;
            if (to_report) begin
               dir_ch   <= best_ch;
               dir_peak <= best_peak;
               hit_mask <= hit_nxt;
            end
         end
      end
   end

   assign detected  = (state != S_IDLE);
   assign dir_valid = (state == S_REPORT);

endmodule

// File: tb/tb_gunshot_direction_detector.sv
// Directed bench for gunshot_direction_detector (NUM_CH=4, HOLD=3, WINDOW=4, COOLDOWN=8).
module tb_gunshot_direction_detector;

   logic               clk = 1'b0;
   logic               reset, enable, cfg_we, in_valid;
   logic [1:0]         kernel_size, cfg_sel;
   logic [15:0]        cfg_thr;
   logic [63:0]        in_data;
   logic               detected, dir_valid;
   logic [1:0]         dir_ch;
   logic signed [15:0] dir_peak;
   logic [3:0]         hit_mask;

   int errors   = 0;
   int checks   = 0;
   int dv_count = 0;

   gunshot_direction_detector #(
      .NUM_CH(4), .DATA_W(16), .HOLD(3), .WINDOW(4), .COOLDOWN(8)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .kernel_size(kernel_size),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_thr(cfg_thr),
      .in_valid(in_valid), .in_data(in_data),
      .detected(detected), .dir_valid(dir_valid), .dir_ch(dir_ch),
      .dir_peak(dir_peak), .hit_mask(hit_mask)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (dir_valid === 1'b1) dv_count++;

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send(input logic v, input int c0, input int c1, input int c2, input int c3);
      in_valid = v;
      in_data  = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
      @(posedge clk);
      #1;
   endtask

   task automatic cool(input int n);
      repeat (n) send(1'b1, -5000, -5000, -5000, -5000);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; kernel_size = 2'd0;
      cfg_we = 1'b0; cfg_sel = 2'd0; cfg_thr = '0;
      in_valid = 1'b0; in_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_detected", detected, 0);
      check("rst_dir_valid", dir_valid, 0);
      check("rst_dir_ch", dir_ch, 0);
      check("rst_dir_peak", dir_peak, 0);
      check("rst_hit_mask", hit_mask, 0);
      reset = 1'b0;

      // Basic event: ch2 debounced trigger, ch1 dominates inside the window
      send(1, 0, 0, 201, 0);
      send(1, 0, 0, 201, 0);
      check("s1_pre_trig", detected, 0);
      send(1, 0, 0, 201, 0);
      check("s1_trig_det", detected, 1);
      send(1, 0, 900, 0, 0);
      send(1, 0, 0, 0, 0);
      check("s1_no_early_dv", dir_valid, 0);
      send(1, 0, 0, 0, 0);
      check("s1_dv", dir_valid, 1);
      check("s1_ch", dir_ch, 1);
      check("s1_peak", dir_peak, 900);
      check("s1_hit", hit_mask, 4'b0110);
      send(0, 0, 0, 0, 0);
      check("s1_dv_pulse", dir_valid, 0);
      check("s1_ch_hold", dir_ch, 1);
      cool(7);
      check("s1_cd_busy", detected, 1);
      cool(1);
      check("s1_cd_done", detected, 0);
      check("s1_dv_count", dv_count, 1);

      // Debounce broken by a gap, and equality with threshold is not over
      send(1, 300, 0, 0, 0);
      send(1, 300, 0, 0, 0);
      send(1, 0, 0, 0, 0);
      send(1, 300, 0, 0, 0);
      send(1, 300, 0, 0, 0);
      check("s2_debounce", detected, 0);
      repeat (4) send(1, 200, 0, 0, 0);
      check("s2_strict", detected, 0);
      check("s2_dv_count", dv_count, 1);

      // Tie between all channels resolves to the lowest index
      kernel_size = 2'd2;
      repeat (4) send(1, 1500, 1500, 1500, 1500);
      send(1, 0, 0, 0, 0);
      send(1, 0, 0, 0, 0);
      check("s3_dv", dir_valid, 1);
      check("s3_ch", dir_ch, 0);
      check("s3_peak", dir_peak, 1500);
      check("s3_hit", hit_mask, 4'b1111);

      // Burst during cooldown is ignored; invalid cycles do not advance anything
      send(0, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         send(1, 0, 0, 0, 5000);
         send(0, 0, 0, 0, 5000);
      end
      check("s4_cd_exit", detected, 0);
      check("s4_cd_ignored", dv_count, 2);
      send(1, 0, 0, 0, 5000);
      send(0, 0, 0, 0, 5000);
      send(1, 0, 0, 0, 5000);
      send(0, 0, 0, 0, 5000);
      check("s4_gap_no_trig", detected, 0);
      send(1, 0, 0, 0, 5000);
      check("s4_trig", detected, 1);
      send(0, 0, 0, 0, 5000);
      send(1, 0, 0, 0, 5000);
      send(0, 0, 0, 0, 5000);
      send(1, 0, 0, 0, 5000);
      repeat (4) send(0, 0, 0, 0, 5000);
      check("s4_gap_no_dv", dir_valid, 0);
      send(1, 0, 0, 0, 5000);
      check("s4_dv", dir_valid, 1);
      check("s4_ch", dir_ch, 3);
      check("s4_peak", dir_peak, 5000);
      check("s4_hit", hit_mask, 4'b1000);
      send(0, 0, 0, 0, 0);
      cool(8);
      check("s4_idle", detected, 0);

      // Threshold write, ignored cfg_sel=3 write, kernel_size latched at trigger
      cfg_we = 1'b1; cfg_sel = 2'd1; cfg_thr = 16'(-50);
      send(0, 0, 0, 0, 0);
      cfg_sel = 2'd3; cfg_thr = 16'(-1000);
      send(0, 0, 0, 0, 0);
      cfg_we = 1'b0;
      kernel_size = 2'd1;
      repeat (3) send(1, -100, -100, -100, -40);
      kernel_size = 2'd3;
      repeat (3) send(1, -100, -100, -100, -40);
      check("s5_dv", dir_valid, 1);
      check("s5_ch", dir_ch, 3);
      check("s5_peak", dir_peak, -40);
      check("s5_hit_ksl", hit_mask, 4'b1000);
      send(0, 0, 0, 0, 0);
      cool(8);
      repeat (5) send(1, 5000, 5000, 5000, 5000);
      check("s5_ks3_off", detected, 0);
      kernel_size = 2'd2;
      repeat (5) send(1, 1000, -5000, -5000, -5000);
      check("s5_thr2_kept", detected, 0);
      kernel_size = 2'd0;
      repeat (5) send(1, 200, -5000, -5000, -5000);
      check("s5_thr0_kept", detected, 0);
      check("s5_dv_count", dv_count, 4);

      // enable drop mid-capture: back to IDLE, results kept
      repeat (3) send(1, -5000, 300, -5000, -5000);
      check("s6_trig", detected, 1);
      repeat (2) send(1, -5000, 300, -5000, -5000);
      enable = 1'b0;
      send(1, -5000, 300, -5000, -5000);
      check("s6_en_idle", detected, 0);
      check("s6_en_no_dv", dir_valid, 0);
      check("s6_en_ch_kept", dir_ch, 3);
      check("s6_en_peak_kept", dir_peak, -40);
      enable = 1'b1;
      repeat (2) send(1, -5000, 300, -5000, -5000);
      check("s6_run_fresh", detected, 0);
      send(1, -5000, 300, -5000, -5000);
      check("s6_retrig", detected, 1);
      send(1, -5000, 300, -5000, -5000);

      // async reset mid-capture aborts the event and restores thresholds
      #2 reset = 1'b1;
      #1;
      check("s6_rst_det", detected, 0);
      check("s6_rst_dv", dir_valid, 0);
      check("s6_rst_ch", dir_ch, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      kernel_size = 2'd1;
      repeat (4) send(1, -5000, 400, -5000, -5000);
      check("s6_thr1_default", detected, 0);
      repeat (3) send(1, -5000, 600, -5000, -5000);
      check("s6_thr1_trig", detected, 1);
      check("s6_dv_count", dv_count, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
